// File: rtl/membus_arbiter_if.sv
// Memory bus handshake bundle: requester drives valid/payload, responder drives ready and
// a one-cycle rvalid/rdata per accepted request.
interface Membus #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
    modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/membus_arbiter.sv
// Two-to-one Membus arbiter: data-over-ifetch priority with a starvation guard,
// one outstanding transaction, response steered back to the issuing port.
module membus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input logic   clk,
    input logic   rst,
    Membus.slave  i_membus,
    Membus.slave  d_membus,
    Membus.master membus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_IFETCH, OWN_DATA} owner_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    owner_t     owner, owner_nxt;
    logic [7:0] starve_cnt;
    logic       starved, gnt_i, gnt_d, hs;

    // Grants are masked during reset so every output reads 0 while rst is low.
    assign starved = (starve_cnt == LIMIT);
    assign gnt_i   = rst && i_membus.valid && (!d_membus.valid || starved);
    assign gnt_d   = rst && d_membus.valid && !gnt_i;

    assign membus.valid = gnt_i | gnt_d;
    assign membus.addr  = gnt_i ? i_membus.addr  : gnt_d ? d_membus.addr  : '0;
    assign membus.wen   = gnt_i ? i_membus.wen   : gnt_d ? d_membus.wen   : 1'b0;
    assign membus.wdata = gnt_i ? i_membus.wdata : gnt_d ? d_membus.wdata : '0;
    assign membus.wmask = gnt_i ? i_membus.wmask : gnt_d ? d_membus.wmask : '0;

    assign i_membus.ready = gnt_i & membus.ready;
    assign d_membus.ready = gnt_d & membus.ready;

    assign hs = membus.valid & membus.ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) owner <= OWN_NONE;
        else      owner <= owner_nxt;
    end

    // A new handshake in the response cycle takes ownership in the same edge.
    always_comb begin
        owner_nxt = owner;
        if (hs)                owner_nxt = gnt_i ? OWN_IFETCH : OWN_DATA;
        else if (membus.rvalid) owner_nxt = OWN_NONE;
    end

    always_comb begin
        i_membus.rvalid = 1'b0;
        i_membus.rdata  = '0;
        d_membus.rvalid = 1'b0;
        d_membus.rdata  = '0;
        if (membus.rvalid && owner == OWN_IFETCH) begin
            i_membus.rvalid = 1'b1;
            i_membus.rdata  = membus.rdata;
        end
        if (membus.rvalid && owner == OWN_DATA) begin
            d_membus.rvalid = 1'b1;
            d_membus.rdata  = membus.rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                starve_cnt <= '0;
        else if (!i_membus.valid || (hs && gnt_i)) starve_cnt <= '0;
        else if (!starved)                       starve_cnt <= starve_cnt + 8'd1;
    end

    ap_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
        !(membus.rvalid && owner == OWN_NONE))
        else $warning("membus_arbiter: rvalid with no outstanding transaction dropped");
endmodule

// File: tb/tb_membus_arbiter.sv
// Cycle-table bench for membus_arbiter: each row drives one cycle of requester and
// downstream inputs and checks every combinational output before the next rising edge.
module tb_membus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    Membus i_bus();
    Membus d_bus();
    Membus m_bus();

    membus_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .i_membus(i_bus), .d_membus(d_bus), .membus(m_bus)
    );

    typedef struct {
        string       name;
        logic        rst, iv;
        logic [31:0] ia;
        logic        dv, dwen;
        logic [31:0] da, dwd;
        logic [3:0]  dwm;
        logic        rdy, rv;
        logic [31:0] rd;
        logic [137:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    // exp packs {mv, maddr, mwen, mwdata, mwmask, iready, dready, irvalid, irdata, drvalid, drdata}
    function automatic vec_t mk(string name, logic r, logic iv, logic [31:0] ia,
                                logic dv, logic dwen, logic [31:0] da, logic [31:0] dwd,
                                logic [3:0] dwm, logic rdy, logic rv, logic [31:0] rd,
                                logic mv, logic [31:0] ma, logic mwen, logic [31:0] mwd,
                                logic [3:0] mwm, logic ir, logic dr, logic irv,
                                logic [31:0] ird, logic drv, logic [31:0] drd);
        vec_t v;
        v.name = name; v.rst = r; v.iv = iv; v.ia = ia; v.dv = dv; v.dwen = dwen;
        v.da = da; v.dwd = dwd; v.dwm = dwm; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.exp = {mv, ma, mwen, mwd, mwm, ir, dr, irv, ird, drv, drd};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [137:0] act;
        @(negedge clk);
        rst = v.rst;
        i_bus.valid = v.iv; i_bus.addr = v.ia; i_bus.wen = 1'b0; i_bus.wdata = '0; i_bus.wmask = '0;
        d_bus.valid = v.dv; d_bus.addr = v.da; d_bus.wen = v.dwen; d_bus.wdata = v.dwd; d_bus.wmask = v.dwm;
        m_bus.ready = v.rdy; m_bus.rvalid = v.rv; m_bus.rdata = v.rd;
        #1;
        act = {m_bus.valid, m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask, i_bus.ready,
               d_bus.ready, i_bus.rvalid, i_bus.rdata, d_bus.rvalid, d_bus.rdata};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", v.name, act, v.exp);
        end
    endtask

    initial begin
        // name rst iv ia | dv dwen da dwd dwm | rdy rv rd || mv ma mwen mwd mwm ir dr irv ird drv drd
        vecs.push_back(mk("reset_outputs", 0,1,32'h4, 1,0,32'h100,0,0, 1,1,32'h55, 0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk("if_accept",     1,1,32'h0, 0,0,0,0,0, 1,0,0, 1,32'h0,0,0,0, 1,0,0,0,0,0));
        vecs.push_back(mk("if_wait",       1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk("if_resp",       1,0,0, 0,0,0,0,0, 1,1,32'h13, 0,0,0,0,0, 0,0,1,32'h13,0,0));
        vecs.push_back(mk("spurious_rv",   1,0,0, 0,0,0,0,0, 0,1,32'h77, 0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk("both_data_win", 1,1,32'h4, 1,1,32'h8000_0000,32'hDEAD,4'hF, 1,0,0,
                          1,32'h8000_0000,1,32'hDEAD,4'hF, 0,1,0,0,0,0));
        vecs.push_back(mk("if_busy_wait",  1,1,32'h4, 0,0,0,0,0, 0,0,0, 1,32'h4,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk("wr_resp_if_iss",1,1,32'h4, 0,0,0,0,0, 1,1,32'h0, 1,32'h4,0,0,0, 1,0,0,0,1,0));
        vecs.push_back(mk("if4_resp",      1,0,0, 0,0,0,0,0, 1,1,32'h1111, 0,0,0,0,0, 0,0,1,32'h1111,0,0));
        vecs.push_back(mk("b2b_0",         1,1,32'h0, 0,0,0,0,0, 1,0,0, 1,32'h0,0,0,0, 1,0,0,0,0,0));
        vecs.push_back(mk("b2b_4",         1,1,32'h4, 0,0,0,0,0, 1,1,32'hA0, 1,32'h4,0,0,0, 1,0,1,32'hA0,0,0));
        vecs.push_back(mk("b2b_8",         1,1,32'h8, 0,0,0,0,0, 1,1,32'hA4, 1,32'h8,0,0,0, 1,0,1,32'hA4,0,0));
        vecs.push_back(mk("b2b_last_resp", 1,0,0, 0,0,0,0,0, 1,1,32'hA8, 0,0,0,0,0, 0,0,1,32'hA8,0,0));
        vecs.push_back(mk("d_read",        1,0,0, 1,0,32'h200,0,0, 1,0,0, 1,32'h200,0,0,0, 0,1,0,0,0,0));
        vecs.push_back(mk("d_read_resp",   1,0,0, 0,0,0,0,0, 1,1,32'hBEEF, 0,0,0,0,0, 0,0,0,0,1,32'hBEEF));
        vecs.push_back(mk("d_read_pre_rst",1,0,0, 1,0,32'h300,0,0, 1,0,0, 1,32'h300,0,0,0, 0,1,0,0,0,0));
        vecs.push_back(mk("mid_reset",     0,1,32'hC, 1,0,32'h300,0,0, 1,1,32'h99, 0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk("stale_rv_drop", 1,0,0, 0,0,0,0,0, 0,1,32'hDEAD, 0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk("post_rst_if",   1,1,32'h10, 0,0,0,0,0, 1,0,0, 1,32'h10,0,0,0, 1,0,0,0,0,0));
        vecs.push_back(mk("post_rst_resp", 1,0,0, 0,0,0,0,0, 1,1,32'h42, 0,0,0,0,0, 0,0,1,32'h42,0,0));

        foreach (vecs[n]) apply(vecs[n]);

        // Starvation: data always valid, ifetch always pending. The guard trips after
        // 8 denied cycles, clears on the ifetch handshake, and trips again 8 later.
        for (int k = 0; k < 20; k++) begin
            logic ig, prev_ig;
            ig      = (k == 8) || (k == 17);
            prev_ig = (k == 9) || (k == 18);
            apply(mk($sformatf("starve_%0d", k), 1, 1, 32'h40, 1, 0, 32'h1000 + k, 0, 0,
                     1, k > 0, k,
                     1, ig ? 32'h40 : 32'h1000 + k, 0, 0, 0,
                     ig, !ig, prev_ig, prev_ig ? k : 0, (k > 0) && !prev_ig,
                     ((k > 0) && !prev_ig) ? k : 0));
        end
        apply(mk("starve_drain", 1,0,0, 0,0,0,0,0, 1,1,32'h14, 0,0,0,0,0, 0,0,0,0,1,32'h14));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Two-to-one memory bus arbiter between the core's instruction-fetch and data-access ports and the single `Membus` request port of the MMIO controller. Grants one request per handshake with fixed data-over-instruction priority and a starvation guard for instruction fetch. Tracks the single outstanding transaction and steers the response (`rvalid`/`rdata`) back to the port that issued it. Issue and completion may overlap in one cycle, so back-to-back transactions run without bubbles.

## Interface
- `STARVE_LIMIT`, default 8: consecutive cycles of pending-but-denied instruction fetch after which ifetch is granted ahead of data; legal range 1..255.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `i_membus`  Membus.slave  eei widths  instruction-fetch requester.
- `d_membus`  Membus.slave  eei widths  data load/store requester.
- `membus`  Membus.master  eei widths  merged request toward the MMIO controller (`valid, addr, wen, wdata, wmask` out; `ready, rvalid, rdata` in).

## Operation
- Registered state:
  - `owner`: NONE/IFETCH/DATA, the port of the outstanding transaction.
  - `starve_cnt`: 8-bit counter, saturates at `STARVE_LIMIT`.
- Grant selection (combinational, every cycle):
  - Data wins if `d_membus.valid`, unless `starve_cnt == STARVE_LIMIT` and `i_membus.valid`; then ifetch wins.
  - Otherwise ifetch wins if `i_membus.valid`.
  - Otherwise no grant.
- Request path: `membus.valid/addr/wen/wdata/wmask` are driven from the granted port. With no grant, `membus.valid=0` and `addr/wen/wdata/wmask=0`.
- Ready: only the granted port sees `ready = membus.ready`. The other port sees `ready=0`.
- Handshake: `membus.valid && membus.ready` sets `owner` to the granted port.
- Completion: `membus.rvalid` with `owner != NONE` drives `rvalid=1` and `rdata=membus.rdata` on the owner port only. The other port gets `rvalid=0`, `rdata=0`.
  - If no new handshake occurs in the same cycle, `owner` becomes NONE.
  - If a new handshake occurs in the same cycle, `owner` takes the new grantee.
- Every accepted request, read or write, completes with exactly one `rvalid` pulse.
- `membus.rvalid` while `owner == NONE` is not forwarded; simulation assertion fires.
- Starvation counter:
  - Increments when `i_membus.valid` and ifetch is not handshaken this cycle.
  - Clears on an ifetch handshake or when `i_membus.valid=0`.
- Requesters hold `valid` and payload stable until `ready`. The arbiter re-evaluates the grant every cycle, so a denied ifetch request may be pre-empted repeatedly until the starvation guard trips.
- At most one transaction is outstanding. The arbiter relies on `membus.ready` being low while the downstream is busy, except in the cycle where it returns `rvalid`.

## Timing
- Reset values (asynchronous, while `rst=0`):
  - `owner=NONE`, `starve_cnt=0`.
  - All outputs 0: `membus.valid`, `i/d_membus.ready`, `i/d_membus.rvalid`, `i/d_membus.rdata`.
- Grant-to-downstream latency: 0 cycles (combinational request and ready path).
- Response latency added: 0 cycles (combinational `rvalid`/`rdata` steering from the registered `owner`).
- Simultaneous `rvalid` and new handshake: response goes to the old owner and `owner` loads the new grantee in the same edge.
- Both ports valid with the counter below the limit: data is granted; ifetch stalls and the counter increments.
- Reset asserted mid-transaction: `owner` clears. A later `rvalid` from the in-flight request is dropped and asserted on. Downstream is also reset by the same `rst`.

## Test plan
- Single ifetch read, addr 0x0000_0000, downstream `rvalid` 2 cycles after accept with rdata 0x13 -> `i_membus.rvalid=1`, rdata 0x13 on that cycle; `d_membus.rvalid=0`; `owner` returns to NONE.
- Both ports valid in cycle 0 (d: write addr 0x8000_0000, wdata 0xDEAD, wmask 0xF; i: read 0x4) -> `membus` carries the data write first; ifetch is issued on the cycle of the write's `rvalid`.
- Data valid continuously for 20 cycles with ifetch pending and `STARVE_LIMIT=8` -> ifetch is granted no later than 8 cycles after becoming pending and `starve_cnt` clears on its handshake.
- Back-to-back ifetch reads 0x0, 0x4, 0x8 with 1-cycle downstream responses -> three handshakes on consecutive response cycles, with no idle cycle on `membus.valid`.
- Spurious `membus.rvalid=1` with `owner=NONE` -> neither port sees `rvalid` and the assertion is reported.
- `rst` pulled low 1 cycle after a data read is accepted, then released, with the stale `rvalid` arriving afterward -> all outputs 0 during reset, stale response not forwarded, and the next ifetch request is accepted normally.
